genome_mutator: RTL and testbench

//  Mutation stage of the GA datapath, directly downstream of the pseudorandom byte generator.

---
 rtl/genome_mutator_pkg.sv | 16 +
 rtl/genome_mutator_replace.sv | 19 +
 rtl/genome_mutator.sv | 110 +++++++++++
 tb/tb_genome_mutator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/genome_mutator_pkg.sv
// Shared types for the GA mutation stage.
//   state_e : FSM encoding of genome_mutator (3-bit)
//   RNG_W   : width of a random draw from the byte generator
package genome_mutator_pkg;
  localparam int RNG_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_P  = 3'd1,
    S_WAIT_P = 3'd2,
    S_REQ_V  = 3'd3,
    S_WAIT_V = 3'd4,
    S_NEXT   = 3'd5,
    S_OUT    = 3'd6
  } state_e;
endpackage

// File: rtl/genome_mutator_replace.sv
// gene_replace: combinational replacement value for one gene.
//   old_gene : gene currently stored
//   rnd      : random byte; low GENE_W bits are the candidate
//   new_gene : candidate, with LSB flipped if it equals old_gene, so a
//              mutation never leaves the gene unchanged
module gene_replace
  import genome_mutator_pkg::*;
#(
  parameter int GENE_W = 4
) (
  input  logic [GENE_W-1:0] old_gene,
  input  logic [RNG_W-1:0]  rnd,
  output logic [GENE_W-1:0] new_gene
);
  logic [GENE_W-1:0] cand;

  assign cand     = rnd[GENE_W-1:0];
  assign new_gene = (cand == old_gene) ? (cand ^ GENE_W'(1)) : cand;
endmodule

// File: rtl/genome_mutator.sv
// genome_mutator: mutation stage of the GA datapath.
// Takes one genome, draws one random byte per gene; a draw below mut_rate
// triggers a second draw that replaces the gene. Emits the mutated genome
// and the number of replaced genes.
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       genome handshake (ready only in IDLE)
//   in_genome, mut_rate     parent genome, threshold (sampled on accept)
//   rng_start               one-cycle request for a random byte
//   rng_value, rng_done     random byte, one-cycle completion pulse
//   out_valid/out_ready     result handshake
//   out_genome, out_mut_count  mutated genome, replaced-gene count
module genome_mutator
  import genome_mutator_pkg::*;
#(
  parameter int GENE_W    = 4,
  parameter int NUM_GENES = 8,
  parameter int CNT_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [GENE_W*NUM_GENES-1:0] in_genome,
  input  logic [RNG_W-1:0]            mut_rate,
  output logic                        rng_start,
  input  logic [RNG_W-1:0]            rng_value,
  input  logic                        rng_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [GENE_W*NUM_GENES-1:0] out_genome,
  output logic [CNT_W-1:0]            out_mut_count
);
  localparam int GW    = GENE_W * NUM_GENES;
  localparam int IDX_W = (NUM_GENES > 1) ? $clog2(NUM_GENES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_GENES - 1);

  state_e            state, nxt;
  logic [GW-1:0]     gen_q;
  logic [RNG_W-1:0]  rate_q;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [GENE_W-1:0] old_gene, new_gene;

  assign old_gene = gen_q[idx*GENE_W +: GENE_W];

  gene_replace #(.GENE_W(GENE_W)) u_replace (
    .old_gene (old_gene),
    .rnd      (rng_value),
    .new_gene (new_gene)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;

  // rng_done is only looked at in the WAIT states; stray pulses elsewhere fall through.
  always_comb begin
    nxt       = state;
    rng_start = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid) nxt = S_REQ_P;
      end
      S_REQ_P:  begin rng_start = 1'b1; nxt = S_WAIT_P; end
      S_WAIT_P: if (rng_done) nxt = (rng_value < rate_q) ? S_REQ_V : S_NEXT;
      S_REQ_V:  begin rng_start = 1'b1; nxt = S_WAIT_V; end
      S_WAIT_V: if (rng_done) nxt = S_NEXT;
      S_NEXT:   nxt = (idx == LAST) ? S_OUT : S_REQ_P;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) nxt = S_IDLE;
      end
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gen_q         <= '0;
      rate_q        <= '0;
      idx           <= '0;
      cnt           <= '0;
      out_genome    <= '0;
      out_mut_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          gen_q  <= in_genome;
          rate_q <= mut_rate;
          idx    <= '0;
          cnt    <= '0;
        end
        S_WAIT_V: if (rng_done) begin
          gen_q[idx*GENE_W +: GENE_W] <= new_gene;
          cnt                         <= cnt + CNT_W'(1);
        end
        // Result registers load once on entry to OUT and hold until the next genome finishes.
        S_NEXT: if (idx == LAST) begin
          out_genome    <= gen_q;
          out_mut_count <= cnt;
        end else begin
          idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_genome_mutator.sv
// Bench for genome_mutator: scripted RNG (fixed latency, values from a queue),
// directed scenarios plus randomized genomes checked against a reference model.
module tb_genome_mutator;
  localparam int GENE_W = 4, NUM_GENES = 8, CNT_W = 4, LR = 9;
  localparam int GW = GENE_W * NUM_GENES;

  logic            clk = 0, rst_n = 0;
  logic            in_valid = 0, in_ready;
  logic [GW-1:0]   in_genome = '0;
  logic [7:0]      mut_rate = '0;
  logic            rng_start;
  logic [7:0]      rng_value = '0;
  logic            model_done = 0, spur = 0, rng_done;
  logic            out_valid, out_ready = 0;
  logic [GW-1:0]   out_genome;
  logic [CNT_W-1:0] out_mut_count;

  assign rng_done = model_done | spur;

  genome_mutator #(.GENE_W(GENE_W), .NUM_GENES(NUM_GENES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_genome(in_genome), .mut_rate(mut_rate), .rng_start(rng_start),
    .rng_value(rng_value), .rng_done(rng_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_genome(out_genome), .out_mut_count(out_mut_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, n_start = 0;
  logic prev_start = 0;
  logic [7:0] rng_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start-pulse counter; also flags any back-to-back start (more than one cycle high).
  always @(negedge clk) begin
    if (rng_start) begin
      n_start++;
      chk("start_one_cycle", prev_start, 0);
    end
    prev_start = rng_start;
  end

  // RNG: sees a request mid-cycle, answers LR cycles later with a one-cycle done.
  initial begin
    forever begin
      @(negedge clk);
      model_done = 0;
      if (rng_start) begin
        repeat (LR - 1) @(negedge clk);
        rng_value  = (rng_q.size() > 0) ? rng_q.pop_front() : 8'($urandom);
        model_done = 1;
      end
    end
  end

  // Reference: walk genes in order, consuming draws as the rules dictate.
  task automatic ref_model(input logic [GW-1:0] g, input logic [7:0] rate,
                           input logic [7:0] d[$], output logic [GW-1:0] og,
                           output int cnt, output int used);
    og = g; cnt = 0; used = 0;
    for (int i = 0; i < NUM_GENES; i++) begin
      int draw, oldv, v;
      draw = d[used]; used++;
      if (draw < rate) begin
        oldv = (g >> (i * GENE_W)) % (1 << GENE_W);
        v = d[used] % (1 << GENE_W); used++;
        if (v == oldv) v = v ^ 1;
        og = og - (GW'(oldv) << (i * GENE_W)) + (GW'(v) << (i * GENE_W));
        cnt++;
      end
    end
  endtask

  task automatic run(input string tag, input logic [GW-1:0] g, input logic [7:0] rate,
                     input logic [7:0] d[$], input int hold, input bit spur_req);
    logic [GW-1:0] exp_g;
    int exp_c, used, t, s0;
    ref_model(g, rate, d, exp_g, exp_c, used);
    for (int i = 0; i < used; i++) rng_q.push_back(d[i]);
    s0 = n_start;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1; in_genome = g; mut_rate = rate;
    @(negedge clk);
    in_valid = 0; in_genome = $urandom; mut_rate = $urandom;
    chk({tag, "_busy"}, in_ready, 0);
    if (spur_req) spur = 1;
    t = 0;
    while (!out_valid && t < 3000) begin
      @(negedge clk);
      spur = 0;
      t++;
    end
    chk({tag, "_timeout"}, (t >= 3000), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_genome"}, out_genome, exp_g);
      chk({tag, "_hold_count"}, out_mut_count, exp_c);
      chk({tag, "_hold_ready"}, in_ready, 0);
    end
    chk({tag, "_genome"}, out_genome, exp_g);
    chk({tag, "_count"}, out_mut_count, exp_c);
    chk({tag, "_pulses"}, n_start - s0, used);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_drop"}, out_valid, 0);
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_keep"}, out_genome, exp_g);
  endtask

  initial begin
    logic [7:0] d[$];
    int t, s0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_genome", out_genome, 0);
    chk("rst_count", out_mut_count, 0);
    chk("rst_start", rng_start, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    // 1: rate 0 never mutates, one draw per gene
    d = {};
    repeat (NUM_GENES) d.push_back(8'($urandom));
    run("rate0", 32'h12345678, 8'h00, d, 0, 0);
    chk("rate0_exact", out_genome, 32'h12345678);

    // 2: single mutation of gene 0
    d = {8'h10, 8'hA5};
    repeat (NUM_GENES - 1) d.push_back(8'hFF);
    run("one_mut", 32'h12345678, 8'h80, d, 0, 0);
    chk("one_mut_exact", out_genome, 32'h12345675);

    // 3: rate 0xFF, replacement equals old gene -> LSB forced
    d = {8'h00, 8'h08};
    repeat (NUM_GENES - 1) d.push_back(8'hFF);
    run("force", 32'h00000008, 8'hFF, d, 0, 0);
    chk("force_exact", out_genome, 32'h00000009);

    // 4: backpressure, then the next genome goes through
    d = {};
    repeat (2 * NUM_GENES) d.push_back(8'($urandom));
    run("bp", 32'($urandom), 8'h60, d, 5, 0);
    d = {};
    repeat (2 * NUM_GENES) d.push_back(8'($urandom));
    run("bp_next", 32'($urandom), 8'hA0, d, 0, 0);

    // 5: reset during WAIT_V, RNG answer lands after release
    rng_q.push_back(8'h00); rng_q.push_back(8'h33);
    s0 = n_start;
    @(negedge clk);
    in_valid = 1; in_genome = 32'hCAFEF00D; mut_rate = 8'hFF;
    @(negedge clk);
    in_valid = 0;
    t = 0;
    while (n_start - s0 < 2 && t < 200) begin @(negedge clk); t++; end
    chk("rst_mid_timeout", (t >= 200), 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_ready", in_ready, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_genome", out_genome, 0);
    chk("rst_mid_count", out_mut_count, 0);
    chk("rst_mid_start", rng_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (LR + 5) @(negedge clk);
    chk("rst_mid_idle", in_ready, 1);
    chk("rst_mid_no_out", out_valid, 0);
    chk("rst_mid_no_req", n_start - s0, 2);
    d = {};
    repeat (NUM_GENES) d.push_back(8'($urandom));
    run("after_rst", 32'h89ABCDEF, 8'h00, d, 0, 0);

    // 6: spurious done in IDLE and in REQ_P, otherwise scenario 2
    @(negedge clk); spur = 1;
    @(negedge clk); spur = 0;
    chk("spur_idle_ready", in_ready, 1);
    chk("spur_idle_start", rng_start, 0);
    d = {8'h10, 8'hA5};
    repeat (NUM_GENES - 1) d.push_back(8'hFF);
    run("spur", 32'h12345678, 8'h80, d, 0, 1);
    chk("spur_exact", out_genome, 32'h12345675);

    // randomized genomes, draws biased so both paths are exercised
    for (int k = 0; k < 12; k++) begin
      logic [7:0] rate;
      rate = (k == 0) ? 8'hFF : 8'($urandom);
      d = {};
      repeat (2 * NUM_GENES) d.push_back(($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom));
      run("rand", 32'($urandom), rate, d, $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
